// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU memory-bus responder.
package mem_bus_pkg;

  localparam int unsigned BUS_AW = 27;
  localparam int unsigned BUS_DW = 32;

  localparam int unsigned ERR_ACCESS  = 0;
  localparam int unsigned ERR_TIMEOUT = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROM_WAIT,
    ST_EXT_WAIT,
    ST_RESPOND
  } state_e;

  typedef enum logic [1:0] {
    REG_SDRAM,
    REG_IO,
    REG_ROM,
    REG_NONE
  } region_e;

endpackage

// File: rtl/mem_bus_decode.sv
// Combinational address decoder: region select plus window-relative offsets.
module mem_bus_decode
  import mem_bus_pkg::*;
#(
  parameter logic [BUS_AW-1:0] SDRAM_WORDS = 27'h0800000,
  parameter logic [BUS_AW-1:0] IO_BASE     = 27'h7000000,
  parameter logic [BUS_AW-1:0] IO_WORDS    = 27'h0000400,
  parameter logic [BUS_AW-1:0] ROM_BASE    = 27'h7800000,
  parameter int unsigned       ROM_AW      = 10
) (
  input  logic [BUS_AW-1:0] addr,
  output region_e           region,
  output logic [BUS_AW-1:0] io_off,
  output logic [ROM_AW-1:0] rom_off
);

  // One bit wider than the bus so a 2^ROM_AW window never truncates.
  localparam logic [BUS_AW:0] ROM_WORDS = {{BUS_AW{1'b0}}, 1'b1} << ROM_AW;

  logic [BUS_AW-1:0] rom_rel;
  logic              in_rom;
  logic              in_io;
  logic              in_sdram;

  always_comb begin
    rom_rel  = addr - ROM_BASE;
    io_off   = addr - IO_BASE;
    rom_off  = rom_rel[ROM_AW-1:0];
    in_rom   = (addr >= ROM_BASE) && ({1'b0, rom_rel} < ROM_WORDS);
    in_io    = (addr >= IO_BASE) && (io_off < IO_WORDS);
    in_sdram = (addr < SDRAM_WORDS);

    if (in_rom) begin
      region = REG_ROM;
    end else if (in_io) begin
      region = REG_IO;
    end else if (in_sdram) begin
      region = REG_SDRAM;
    end else begin
      region = REG_NONE;
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Bus target end: decodes each request, runs the SDRAM/IO/ROM access and
// returns a one-cycle bus_done with read data, guarded by a watchdog.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter logic [BUS_AW-1:0] SDRAM_WORDS = 27'h0800000,
  parameter logic [BUS_AW-1:0] IO_BASE     = 27'h7000000,
  parameter logic [BUS_AW-1:0] IO_WORDS    = 27'h0000400,
  parameter logic [BUS_AW-1:0] ROM_BASE    = 27'h7800000,
  parameter int unsigned       ROM_AW      = 10,
  parameter int unsigned       TIMEOUT     = 1023
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [BUS_AW-1:0] bus_addr,
  input  logic [BUS_DW-1:0] bus_data,
  input  logic              bus_we,
  input  logic              bus_start,
  output logic [BUS_DW-1:0] bus_q,
  output logic              bus_done,

  output logic [BUS_AW-1:0] sdram_addr,
  output logic [BUS_DW-1:0] sdram_data,
  output logic              sdram_we,
  output logic              sdram_start,
  input  logic [BUS_DW-1:0] sdram_q,
  input  logic              sdram_done,

  output logic [BUS_AW-1:0] io_addr,
  output logic [BUS_DW-1:0] io_data,
  output logic              io_we,
  output logic              io_start,
  input  logic [BUS_DW-1:0] io_q,
  input  logic              io_done,

  output logic [ROM_AW-1:0] rom_addr,
  input  logic [BUS_DW-1:0] rom_q,

  input  logic              err_clear,
  output logic [1:0]        err
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BUS_DW-1:0] rdata_q, rdata_d;
  logic              bus_done_q, bus_done_d;
  logic [1:0]        err_q, err_d;
  logic [1:0]        err_set;

  logic [BUS_AW-1:0] sdram_addr_q, sdram_addr_d;
  logic [BUS_DW-1:0] sdram_data_q, sdram_data_d;
  logic              sdram_we_q, sdram_we_d;
  logic              sdram_start_q, sdram_start_d;

  logic [BUS_AW-1:0] io_addr_q, io_addr_d;
  logic [BUS_DW-1:0] io_data_q, io_data_d;
  logic              io_we_q, io_we_d;
  logic              io_start_q, io_start_d;

  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;

  region_e           region;
  logic [BUS_AW-1:0] io_off;
  logic [ROM_AW-1:0] rom_off;
  logic              access_fault;

  mem_bus_decode #(
    .SDRAM_WORDS (SDRAM_WORDS),
    .IO_BASE     (IO_BASE),
    .IO_WORDS    (IO_WORDS),
    .ROM_BASE    (ROM_BASE),
    .ROM_AW      (ROM_AW)
  ) u_decode (
    .addr    (bus_addr),
    .region  (region),
    .io_off  (io_off),
    .rom_off (rom_off)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rdata_d       = rdata_q;
    err_set       = '0;
    access_fault  = 1'b0;
    sdram_addr_d  = sdram_addr_q;
    sdram_data_d  = sdram_data_q;
    sdram_we_d    = sdram_we_q;
    sdram_start_d = sdram_start_q;
    io_addr_d     = io_addr_q;
    io_data_d     = io_data_q;
    io_we_d       = io_we_q;
    io_start_d    = io_start_q;
    rom_addr_d    = rom_addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus_start) begin
          unique case (region)
            REG_SDRAM: begin
              sdram_addr_d  = bus_addr;
              sdram_data_d  = bus_data;
              sdram_we_d    = bus_we;
              sdram_start_d = 1'b1;
              cnt_d         = '0;
              state_d       = ST_EXT_WAIT;
            end
            REG_IO: begin
              io_addr_d  = io_off;
              io_data_d  = bus_data;
              io_we_d    = bus_we;
              io_start_d = 1'b1;
              cnt_d      = '0;
              state_d    = ST_EXT_WAIT;
            end
            REG_ROM: begin
              if (bus_we) begin
                access_fault = 1'b1;
              end else begin
                rom_addr_d = rom_off;
                state_d    = ST_ROM_WAIT;
              end
            end
            default: access_fault = 1'b1;
          endcase
        end
      end
      ST_ROM_WAIT: begin
        rdata_d = rom_q;
        state_d = ST_RESPOND;
      end
      ST_EXT_WAIT: begin
        // The active start flag identifies the selected target; done from the
        // other one is ignored. A done on the final count still wins.
        if (sdram_start_q && sdram_done) begin
          rdata_d       = sdram_q;
          sdram_start_d = 1'b0;
          state_d       = ST_RESPOND;
        end else if (io_start_q && io_done) begin
          rdata_d    = io_q;
          io_start_d = 1'b0;
          state_d    = ST_RESPOND;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d              = '0;
          sdram_start_d        = 1'b0;
          io_start_d           = 1'b0;
          err_set[ERR_TIMEOUT] = 1'b1;
          state_d              = ST_RESPOND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    if (access_fault) begin
      rdata_d             = '0;
      err_set[ERR_ACCESS] = 1'b1;
      state_d             = ST_RESPOND;
    end

    err_d      = (err_clear ? 2'b00 : err_q) | err_set;
    bus_done_d = (state_d == ST_RESPOND);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      rdata_q       <= '0;
      bus_done_q    <= 1'b0;
      err_q         <= '0;
      sdram_addr_q  <= '0;
      sdram_data_q  <= '0;
      sdram_we_q    <= 1'b0;
      sdram_start_q <= 1'b0;
      io_addr_q     <= '0;
      io_data_q     <= '0;
      io_we_q       <= 1'b0;
      io_start_q    <= 1'b0;
      rom_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rdata_q       <= rdata_d;
      bus_done_q    <= bus_done_d;
      err_q         <= err_d;
      sdram_addr_q  <= sdram_addr_d;
      sdram_data_q  <= sdram_data_d;
      sdram_we_q    <= sdram_we_d;
      sdram_start_q <= sdram_start_d;
      io_addr_q     <= io_addr_d;
      io_data_q     <= io_data_d;
      io_we_q       <= io_we_d;
      io_start_q    <= io_start_d;
      rom_addr_q    <= rom_addr_d;
    end
  end

  assign bus_q       = rdata_q;
  assign bus_done    = bus_done_q;
  assign err         = err_q;
  assign sdram_addr  = sdram_addr_q;
  assign sdram_data  = sdram_data_q;
  assign sdram_we    = sdram_we_q;
  assign sdram_start = sdram_start_q;
  assign io_addr     = io_addr_q;
  assign io_data     = io_data_q;
  assign io_we       = io_we_q;
  assign io_start    = io_start_q;
  assign rom_addr    = rom_addr_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed plus randomized checks of mem_bus_responder against a
// transaction-level reference model (region rules, latency, error bits).
module tb_mem_bus_responder;

  localparam int unsigned TMO   = 8;
  localparam int unsigned SD_W  = 32'h0800000;
  localparam int unsigned IO_B  = 32'h7000000;
  localparam int unsigned IO_W  = 32'h0000400;
  localparam int unsigned ROM_B = 32'h7800000;
  localparam int unsigned ROM_N = 1024;

  localparam int unsigned R_SD   = 0;
  localparam int unsigned R_IO   = 1;
  localparam int unsigned R_ROM  = 2;
  localparam int unsigned R_NONE = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [26:0] bus_addr;
  logic [31:0] bus_data;
  logic        bus_we;
  logic        bus_start;
  logic [31:0] bus_q;
  logic        bus_done;
  logic [26:0] sdram_addr;
  logic [31:0] sdram_data;
  logic        sdram_we;
  logic        sdram_start;
  logic [31:0] sdram_q;
  logic        sdram_done;
  logic [26:0] io_addr;
  logic [31:0] io_data;
  logic        io_we;
  logic        io_start;
  logic [31:0] io_q;
  logic        io_done;
  logic [9:0]  rom_addr;
  logic [31:0] rom_q;
  logic        err_clear;
  logic [1:0]  err;

  logic [31:0] rom_mem [ROM_N];
  assign rom_q = rom_mem[rom_addr];

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned fails  = 0;
  logic [1:0]  exp_err;
  logic [9:0]  exp_rom_addr;

  always #5 clk = ~clk;

  mem_bus_responder #(
    .ROM_AW  (10),
    .TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_addr    (bus_addr),
    .bus_data    (bus_data),
    .bus_we      (bus_we),
    .bus_start   (bus_start),
    .bus_q       (bus_q),
    .bus_done    (bus_done),
    .sdram_addr  (sdram_addr),
    .sdram_data  (sdram_data),
    .sdram_we    (sdram_we),
    .sdram_start (sdram_start),
    .sdram_q     (sdram_q),
    .sdram_done  (sdram_done),
    .io_addr     (io_addr),
    .io_data     (io_data),
    .io_we       (io_we),
    .io_start    (io_start),
    .io_q        (io_q),
    .io_done     (io_done),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .err_clear   (err_clear),
    .err         (err)
  );

  task automatic check(input string tag, input bit ok, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (ok) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned region_of(input logic [26:0] a);
    int unsigned x;
    x = 32'(a);
    if (x >= ROM_B && x < ROM_B + ROM_N) return R_ROM;
    if (x >= IO_B && x < IO_B + IO_W) return R_IO;
    if (x < SD_W) return R_SD;
    return R_NONE;
  endfunction

  function automatic logic [26:0] pick_addr();
    int unsigned k;
    k = $urandom_range(0, 11);
    case (k)
      0:       return 27'($urandom_range(0, SD_W - 1));
      1:       return 27'(SD_W - 1);
      2:       return 27'(SD_W);
      3:       return 27'(IO_B + $urandom_range(0, IO_W - 1));
      4:       return 27'(IO_B - 1);
      5:       return 27'(IO_B + IO_W - 1);
      6:       return 27'(IO_B + IO_W);
      7:       return 27'(ROM_B + $urandom_range(0, ROM_N - 1));
      8:       return 27'(ROM_B - 1);
      9:       return 27'(ROM_B + ROM_N);
      10:      return 27'h7FFFFFF;
      default: return 27'($urandom());
    endcase
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_bus_q"}, bus_q === 32'h0, 64'(bus_q), 64'(0));
    check({tag, "_bus_done"}, bus_done === 1'b0, 64'(bus_done), 64'(0));
    check({tag, "_err"}, err === 2'b00, 64'(err), 64'(0));
    check({tag, "_starts"}, {sdram_start, io_start} === 2'b00, 64'({sdram_start, io_start}), 64'(0));
    check({tag, "_wes"}, {sdram_we, io_we} === 2'b00, 64'({sdram_we, io_we}), 64'(0));
    check({tag, "_addrs"}, {sdram_addr, io_addr, rom_addr} === 64'(0),
          64'({sdram_addr, io_addr, rom_addr}), 64'(0));
    check({tag, "_datas"}, {sdram_data, io_data} === 64'(0), 64'({sdram_data, io_data}), 64'(0));
  endtask

  // d: cycles after the target start becomes visible at which the target
  // pulses done (values above TMO mean it never answers in time).
  task automatic run_txn(input logic [26:0] a, input logic [31:0] wd, input logic w,
                         input int unsigned d, input bit hold, input bit clr);
    int unsigned r, exp_lat, cyc;
    logic [31:0] exp_q, tq, off;
    logic [26:0] exp_io;
    bit          seen, ext;
    r    = region_of(a);
    ext  = (r == R_SD) || (r == R_IO);
    tq   = $urandom();
    cyc  = 0;
    seen = 1'b0;
    exp_io = 27'(32'(a) - IO_B);
    bus_addr  = a;
    bus_data  = wd;
    bus_we    = w;
    bus_start = 1'b1;
    if (bus_done) begin
      @(posedge clk); #1;
      check("done_one_cycle", bus_done === 1'b0, 64'(bus_done), 64'(0));
    end
    if (ext) begin
      if (d <= TMO) begin
        exp_lat = d + 1;
        exp_q   = tq;
      end else begin
        exp_lat    = TMO + 1;
        exp_q      = '0;
        exp_err[1] = 1'b1;
      end
    end else if (r == R_ROM && !w) begin
      off          = 32'(a) - ROM_B;
      exp_lat      = 2;
      exp_q        = rom_mem[off[9:0]];
      exp_rom_addr = off[9:0];
    end else begin
      exp_lat    = 1;
      exp_q      = '0;
      exp_err[0] = 1'b1;
    end

    while (!seen && cyc < 3 * TMO) begin
      @(posedge clk); #1;
      cyc++;
      sdram_done = 1'b0;
      io_done    = 1'b0;
      if (cyc == 1) begin
        if (r == R_SD) begin
          check("sdram_start", sdram_start === 1'b1, 64'(sdram_start), 64'(1));
          check("sdram_addr", sdram_addr === a, 64'(sdram_addr), 64'(a));
          check("sdram_data", sdram_data === wd, 64'(sdram_data), 64'(wd));
          check("sdram_we", sdram_we === w, 64'(sdram_we), 64'(w));
          check("io_idle", io_start === 1'b0, 64'(io_start), 64'(0));
        end else if (r == R_IO) begin
          check("io_start", io_start === 1'b1, 64'(io_start), 64'(1));
          check("io_addr", io_addr === exp_io, 64'(io_addr), 64'(exp_io));
          check("io_data", io_data === wd, 64'(io_data), 64'(wd));
          check("io_we", io_we === w, 64'(io_we), 64'(w));
          check("sdram_idle", sdram_start === 1'b0, 64'(sdram_start), 64'(0));
        end else begin
          check("no_target", {sdram_start, io_start} === 2'b00, 64'({sdram_start, io_start}), 64'(0));
          check("rom_addr", rom_addr === exp_rom_addr, 64'(rom_addr), 64'(exp_rom_addr));
        end
      end
      if (bus_done) begin
        seen = 1'b1;
      end else if (ext) begin
        if (cyc == d) begin
          if (r == R_SD) begin sdram_done = 1'b1; sdram_q = tq; end
          else begin io_done = 1'b1; io_q = tq; end
        end else if (cyc == 1) begin
          if (r == R_SD) begin io_done = 1'b1; io_q = ~tq; end
          else begin sdram_done = 1'b1; sdram_q = ~tq; end
        end
      end
    end

    check("done_seen", seen === 1'b1, 64'(seen), 64'(1));
    check("latency", cyc === exp_lat, 64'(cyc), 64'(exp_lat));
    check("bus_q", bus_q === exp_q, 64'(bus_q), 64'(exp_q));
    check("err", err === exp_err, 64'(err), 64'(exp_err));
    check("starts_low", {sdram_start, io_start} === 2'b00, 64'({sdram_start, io_start}), 64'(0));
    if (!hold) begin
      bus_start = 1'b0;
      @(posedge clk); #1;
      check("done_pulse_end", bus_done === 1'b0, 64'(bus_done), 64'(0));
      check("bus_q_held", bus_q === exp_q, 64'(bus_q), 64'(exp_q));
      if (clr) begin
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        exp_err   = 2'b00;
        check("err_cleared", err === exp_err, 64'(err), 64'(exp_err));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < ROM_N; i++) rom_mem[i] = $urandom();
    rom_mem[5] = 32'hCAFEF00D;
    reset      = 1'b0;
    bus_addr   = '0;
    bus_data   = '0;
    bus_we     = 1'b0;
    bus_start  = 1'b0;
    sdram_q    = '0;
    sdram_done = 1'b0;
    io_q       = '0;
    io_done    = 1'b0;
    err_clear  = 1'b0;
    exp_err      = 2'b00;
    exp_rom_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    run_txn(27'h4000000, 32'h0, 1'b0, 1, 1'b0, 1'b1);
    run_txn(27'(ROM_B + 5), 32'h0, 1'b0, 1, 1'b0, 1'b0);
    run_txn(27'(ROM_B + 5), 32'h55AA55AA, 1'b1, 1, 1'b0, 1'b1);
    run_txn(27'h0000010, 32'h12345678, 1'b1, 7, 1'b0, 1'b0);
    run_txn(27'(IO_B + 3), 32'h0, 1'b0, 3, 1'b0, 1'b0);

    // I/O target never answers; a late done afterwards must be dropped.
    run_txn(27'(IO_B + 3), 32'h0, 1'b0, 100, 1'b0, 1'b0);
    @(posedge clk); #1;
    io_done = 1'b1;
    io_q    = 32'hDEADBEEF;
    @(posedge clk); #1;
    io_done = 1'b0;
    check("late_done_ignored", bus_done === 1'b0, 64'(bus_done), 64'(0));
    check("late_done_bus_q", bus_q === 32'h0, 64'(bus_q), 64'(0));
    check("late_done_err", err === exp_err, 64'(err), 64'(exp_err));
    @(posedge clk); #1;
    check("late_done_quiet", bus_done === 1'b0, 64'(bus_done), 64'(0));
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    exp_err   = 2'b00;
    check("err_clear_timeout", err === exp_err, 64'(err), 64'(exp_err));

    run_txn(27'(SD_W - 1), 32'hA5A5A5A5, 1'b1, TMO, 1'b0, 1'b0);
    run_txn(27'(IO_B + IO_W - 1), 32'h0, 1'b0, TMO + 1, 1'b0, 1'b1);

    run_txn(27'h0000200, 32'h0, 1'b0, 4, 1'b1, 1'b0);
    run_txn(27'(ROM_B + 9), 32'h0, 1'b0, 1, 1'b0, 1'b0);

    // Abort mid-access with reset; err is made nonzero first.
    run_txn(27'h7FFFFFF, 32'h0, 1'b0, 1, 1'b0, 1'b0);
    bus_addr  = 27'h0000123;
    bus_data  = 32'h0BADF00D;
    bus_we    = 1'b1;
    bus_start = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("pre_reset_start", sdram_start === 1'b1, 64'(sdram_start), 64'(1));
    reset = 1'b0;
    #1;
    bus_start = 1'b0;
    check_zero("mid_reset");
    @(posedge clk); #1;
    reset        = 1'b1;
    exp_err      = 2'b00;
    exp_rom_addr = '0;
    @(posedge clk); #1;
    run_txn(27'h0000123, 32'h0BADF00D, 1'b1, 2, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      bit h;
      h = (n != 59) && ($urandom_range(0, 2) == 0);
      run_txn(pick_addr(), $urandom(), 1'($urandom_range(0, 1)),
              $urandom_range(1, TMO + 2), h, !h && ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule
